axi_wr_arbiter: RTL

Shares one single-beat AXI4 write master, 32-bit data, among two word-write requesters. Typical requesters are the SD-card BMP loader pixel path and a test-pattern/overlay writer, both targeting the same frame buffer. The block performs round-robin arbitration, address translation onto the slave base, independent AW/W handshakes and B-response collection, then reports per-requester completion and error status.

---
 rtl/axi_wr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin share of one single-beat AXI4 write master between two word requesters
module axi_wr_arbiter #(
    parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000
) (
    input  logic             m_axi_aclk,
    input  logic             m_axi_aresetn,
    input  logic [1:0]       req_valid,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_data,
    output logic [1:0]       req_ready,
    output logic [1:0]       req_done,
    output logic [1:0]       req_error,
    output logic             grant_id,
    output logic             busy,
    output logic [31:0]      m_axi_awaddr,
    output logic [7:0]       m_axi_awlen,
    output logic [2:0]       m_axi_awsize,
    output logic [1:0]       m_axi_awburst,
    output logic             m_axi_awlock,
    output logic [3:0]       m_axi_awcache,
    output logic [2:0]       m_axi_awprot,
    output logic [3:0]       m_axi_awqos,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    output logic             m_axi_wlast,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    input  logic [1:0]       m_axi_bresp,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    state_t      r_state;
    logic        r_last;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        w_win;
    logic        w_aw_done;
    logic        w_w_done;
    assign w_win     = (&req_valid) ? ~r_last : req_valid[1];
    assign w_aw_done = ~r_awvalid | m_axi_awready;
    assign w_w_done  = ~r_wvalid | m_axi_wready;
    assign busy          = r_state != IDLE;
    assign m_axi_awaddr  = C_M_AXI_TARGET_SLAVE_BASE_ADDR + (r_addr & ~32'h3);
    assign m_axi_awlen   = 8'h0;
    assign m_axi_awsize  = 3'h2;
    assign m_axi_awburst = 2'h1;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'h0;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = r_wvalid;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_data    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            req_ready <= '0;
            req_done  <= '0;
            req_error <= '0;
            grant_id  <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_error <= '0;
            case (r_state)
                // Arbitration waits out the done-pulse cycle, so a write occupies four cycles minimum
                IDLE: if (|req_valid && ~|req_done) begin
                    r_addr    <= req_addr[w_win];
                    r_data    <= req_data[w_win];
                    grant_id  <= w_win;
                    r_last    <= w_win;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    req_ready <= w_win ? 2'b10 : 2'b01;
                    r_state   <= XFER;
                end
                XFER: begin
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: if (m_axi_bvalid) begin
                    r_bready            <= 1'b0;
                    req_done[grant_id]  <= 1'b1;
                    req_error[grant_id] <= m_axi_bresp[1];
                    r_state             <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
